// File: rtl/enc_layer_ctrl_if.sv
// Bundle of every signal between the layer scheduler, the encoder MAC datapath
// and the sequencer. The slave modport is the sequencer's view. The master
// modport is the environment's view: the scheduler, the datapath and the consumer.
interface enc_layer_ctrl_if #(
    parameter int BITSIZE  = 16,
    parameter int LANES    = 6,
    parameter int N_IN_MAX = 10,
    parameter int SELW     = $clog2(N_IN_MAX)
);
    // request side
    logic                       start;
    logic [SELW:0]              n_in;
    logic                       busy;
    logic                       cfg_err;
    // datapath control
    logic [SELW-1:0]            mul_sel;
    logic                       mul_en;
    logic                       acc_load;
    logic                       acc_en;
    logic [BITSIZE*LANES-1:0]   acc_in;
    // result handshake
    logic [BITSIZE*LANES-1:0]   y;
    logic                       out_valid;
    logic                       out_ready;

    modport master (
        output start, n_in, acc_in, out_ready,
        input  busy, cfg_err, mul_sel, mul_en, acc_load, acc_en, y, out_valid
    );

    modport slave (
        input  start, n_in, acc_in, out_ready,
        output busy, cfg_err, mul_sel, mul_en, acc_load, acc_en, y, out_valid
    );
endinterface

// File: rtl/enc_layer_ctrl.sv
// Layer sequencer for the shared encoder MAC array. It runs bias preload, then
// one multiply step per input element, then drains the multiplier pipe. It
// then captures the accumulators and holds the result until the consumer takes it.
module enc_layer_ctrl #(
    parameter int BITSIZE  = 16,
    parameter int LANES    = 6,
    parameter int N_IN_MAX = 10,
    parameter int MUL_LAT  = 1,
    parameter int SELW     = $clog2(N_IN_MAX)
) (
    input  logic             clk,
    input  logic             reset,
    enc_layer_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BIAS    = 3'd1,
        MAC     = 3'd2,
        DRAIN   = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                   state_reg, state_next;
    logic [SELW:0]            n_len_reg, n_len_next;
    logic [SELW-1:0]          k_reg, k_next;
    logic [1:0]               drain_reg, drain_next;
    logic                     cfg_err_reg, cfg_err_next;
    logic [BITSIZE*LANES-1:0] y_reg, y_next;

    logic mul_en_c;
    logic acc_load_c;
    logic acc_en_c;
    logic n_legal;
    logic last_k;
    logic last_drain;

    assign n_legal    = (bus.n_in != '0) && (bus.n_in <= (SELW+1)'(N_IN_MAX));
    assign last_k     = ({1'b0, k_reg} == (n_len_reg - (SELW+1)'(1)));
    assign last_drain = (drain_reg == 2'(MUL_LAT - 1));

    // State, loop counters, error pulse and result buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            n_len_reg   <= '0;
            k_reg       <= '0;
            drain_reg   <= '0;
            cfg_err_reg <= 1'b0;
            y_reg       <= '0;
        end else begin
            state_reg   <= state_next;
            n_len_reg   <= n_len_next;
            k_reg       <= k_next;
            drain_reg   <= drain_next;
            cfg_err_reg <= cfg_err_next;
            y_reg       <= y_next;
        end
    end

    // Next-state logic and per-state datapath strobes.
    always_comb begin
        state_next   = state_reg;
        n_len_next   = n_len_reg;
        k_next       = k_reg;
        drain_next   = drain_reg;
        cfg_err_next = 1'b0;
        y_next       = y_reg;
        mul_en_c     = 1'b0;
        acc_load_c   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    if (n_legal) begin
                        n_len_next = bus.n_in;
                        state_next = BIAS;
                    end else begin
                        cfg_err_next = 1'b1;
                    end
                end
            end
            BIAS: begin
                acc_load_c = 1'b1;
                k_next     = '0;
                state_next = MAC;
            end
            MAC: begin
                mul_en_c = 1'b1;
                if (last_k) begin
                    drain_next = '0;
                    // With no multiplier register the last product lands in
                    // the same cycle, so nothing is left to drain.
                    state_next = (MUL_LAT == 0) ? CAPTURE : DRAIN;
                end else begin
                    k_next = k_reg + 1'b1;
                end
            end
            DRAIN: begin
                drain_next = drain_reg + 2'd1;
                if (last_drain) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                y_next     = bus.acc_in;
                state_next = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // acc_en is mul_en delayed to line up with the registered product.
    generate
        if (MUL_LAT == 0) begin : g_no_pipe
            assign acc_en_c = mul_en_c;
        end else begin : g_pipe
            for (genvar gi = 0; gi < MUL_LAT; gi++) begin : g_stage
                logic d;
                logic q_reg;
                if (gi == 0) begin : g_first
                    assign d = mul_en_c;
                end else begin : g_chain
                    assign d = g_stage[gi-1].q_reg;
                end
                // One register stage of the acc_en delay line.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        q_reg <= 1'b0;
                    end else begin
                        q_reg <= d;
                    end
                end
            end
            assign acc_en_c = g_stage[MUL_LAT-1].q_reg;
        end
    endgenerate

    assign bus.busy      = (state_reg != IDLE);
    assign bus.cfg_err   = cfg_err_reg;
    assign bus.mul_en    = mul_en_c;
    assign bus.mul_sel   = mul_en_c ? k_reg : '0;
    assign bus.acc_load  = acc_load_c;
    assign bus.acc_en    = acc_en_c;
    assign bus.y         = y_reg;
    assign bus.out_valid = (state_reg == DONE);

endmodule

// File: tb/tb_enc_layer_ctrl.sv
// Directed bench for enc_layer_ctrl with three controllers, one each for
// MUL_LAT = 1, 0 and 3. Each controller drives a small behavioural datapath.
// Each lane loads the bias 0x0100 + lane. Each accumulate step adds k*10, so
// n_in=10 gives 0x02C2 + lane.
module tb_enc_layer_ctrl;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_s     [NI];
    logic [4:0]  n_in_s      [NI];
    logic        out_ready_s [NI];
    logic        busy_s      [NI];
    logic        cfg_err_s   [NI];
    logic [3:0]  mul_sel_s   [NI];
    logic        mul_en_s    [NI];
    logic        acc_load_s  [NI];
    logic        acc_en_s    [NI];
    logic        out_valid_s [NI];
    logic [95:0] y_s         [NI];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        localparam int L = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);

        enc_layer_ctrl_if #(.BITSIZE(16), .LANES(6), .N_IN_MAX(10)) ifc ();

        assign ifc.start     = start_s[gi];
        assign ifc.n_in      = n_in_s[gi];
        assign ifc.out_ready = out_ready_s[gi];
        assign busy_s[gi]      = ifc.busy;
        assign cfg_err_s[gi]   = ifc.cfg_err;
        assign mul_sel_s[gi]   = ifc.mul_sel;
        assign mul_en_s[gi]    = ifc.mul_en;
        assign acc_load_s[gi]  = ifc.acc_load;
        assign acc_en_s[gi]    = ifc.acc_en;
        assign out_valid_s[gi] = ifc.out_valid;
        assign y_s[gi]         = ifc.y;

        enc_layer_ctrl #(
            .BITSIZE(16), .LANES(6), .N_IN_MAX(10), .MUL_LAT(L)
        ) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (ifc)
        );

        // Behavioural datapath with a product pipe as deep as MUL_LAT.
        logic [15:0] pp [3];
        logic [15:0] prod;
        logic [95:0] acc;

        always @(posedge clk) begin
            pp[0] <= 16'(ifc.mul_sel * 10);
            pp[1] <= pp[0];
            pp[2] <= pp[1];
        end

        assign prod = (L == 0) ? 16'(ifc.mul_sel * 10) : pp[(L == 0) ? 0 : L - 1];

        always @(posedge clk) begin
            for (int l = 0; l < 6; l++) begin
                if (ifc.acc_load) begin
                    acc[16*l +: 16] <= 16'h0100 + 16'(l);
                end else if (ifc.acc_en) begin
                    acc[16*l +: 16] <= acc[16*l +: 16] + prod;
                end
            end
        end

        assign ifc.acc_in = acc;
    end

    typedef struct {
        int          inst;
        int          n;
        logic        err;
        int          edges;
        logic [15:0] base;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] yexp(input logic [15:0] base);
        logic [95:0] r;
        for (int l = 0; l < 6; l++) begin
            r[16*l +: 16] = base + 16'(l);
        end
        return r;
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
    endfunction

    // Issue one legal request and follow it to out_valid. If release is set,
    // also follow it through the output handshake.
    task automatic run_pass(input int i, input int n, input int exp_edges,
                            input logic [15:0] base, input logic release_out,
                            input string name);
        int edges, k, mul_cnt, acc_cnt, first_mul, first_acc, load_cnt;
        logic sel_ok, overlap;
        start_s[i] = 1'b1;
        n_in_s[i]  = 5'(n);
        tick();
        start_s[i] = 1'b0;
        n_in_s[i]  = 5'd2;    // changes after accept must be ignored
        chk({name, "_accept"}, {busy_s[i], acc_load_s[i], mul_en_s[i]}, 3'b110);
        edges = 0; k = 0; mul_cnt = 0; acc_cnt = 0; load_cnt = 0;
        first_mul = -1; first_acc = -1; sel_ok = 1'b1; overlap = 1'b0;
        while (!out_valid_s[i] && edges < 60) begin
            tick();
            edges++;
            if (mul_en_s[i]) begin
                if (int'(mul_sel_s[i]) != k) sel_ok = 1'b0;
                if (first_mul < 0) first_mul = edges;
                k++;
                mul_cnt++;
            end
            if (acc_en_s[i]) begin
                if (first_acc < 0) first_acc = edges;
                acc_cnt++;
            end
            if (acc_load_s[i]) load_cnt++;
            if (acc_load_s[i] && acc_en_s[i]) overlap = 1'b1;
        end
        chk({name, "_latency"}, 128'(edges), 128'(exp_edges));
        chk({name, "_mul_seq"}, {sel_ok, 8'(mul_cnt), 8'(first_mul)}, {1'b1, 8'(n), 8'd1});
        chk({name, "_acc_lag"}, {8'(acc_cnt), 8'(first_acc - first_mul)},
            {8'(n), 8'(lat_of(i))});
        chk({name, "_no_overlap"}, {overlap, 8'(load_cnt)}, 9'd0);
        chk({name, "_y"}, y_s[i], yexp(base));
        if (release_out) begin
            tick();
            chk({name, "_release"}, {out_valid_s[i], busy_s[i]}, 2'b00);
        end
    endtask

    initial begin
        int   edges;
        logic stable, no_err;
        logic [95:0] ystore;

        vecs[0]  = '{inst: 0, n: 10, err: 1'b0, edges: 13, base: 16'h02C2};
        vecs[1]  = '{inst: 0, n: 3,  err: 1'b0, edges: 6,  base: 16'h011E};
        vecs[2]  = '{inst: 1, n: 1,  err: 1'b0, edges: 3,  base: 16'h0100};
        vecs[3]  = '{inst: 2, n: 1,  err: 1'b0, edges: 6,  base: 16'h0100};
        vecs[4]  = '{inst: 1, n: 10, err: 1'b0, edges: 12, base: 16'h02C2};
        vecs[5]  = '{inst: 2, n: 4,  err: 1'b0, edges: 9,  base: 16'h013C};
        vecs[6]  = '{inst: 0, n: 1,  err: 1'b0, edges: 4,  base: 16'h0100};
        vecs[7]  = '{inst: 2, n: 10, err: 1'b0, edges: 15, base: 16'h02C2};
        vecs[8]  = '{inst: 0, n: 0,  err: 1'b1, edges: 0,  base: 16'h0000};
        vecs[9]  = '{inst: 0, n: 11, err: 1'b1, edges: 0,  base: 16'h0000};
        vecs[10] = '{inst: 1, n: 0,  err: 1'b1, edges: 0,  base: 16'h0000};
        vecs[11] = '{inst: 2, n: 31, err: 1'b1, edges: 0,  base: 16'h0000};

        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start_s[i]     = 1'b0;
            n_in_s[i]      = 5'd0;
            out_ready_s[i] = 1'b1;
        end
        tick();
        tick();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset_state%0d", i),
                {busy_s[i], cfg_err_s[i], mul_en_s[i], acc_load_s[i], acc_en_s[i],
                 out_valid_s[i], mul_sel_s[i], y_s[i]}, '0);
        end
        reset = 1'b0;
        tick();

        // Table-driven legal passes and illegal requests.
        for (int v = 0; v < 12; v++) begin
            if (!vecs[v].err) begin
                run_pass(vecs[v].inst, vecs[v].n, vecs[v].edges, vecs[v].base, 1'b1,
                         $sformatf("vec%0d", v));
            end else begin
                start_s[vecs[v].inst] = 1'b1;
                n_in_s[vecs[v].inst]  = 5'(vecs[v].n);
                tick();
                start_s[vecs[v].inst] = 1'b0;
                chk($sformatf("vec%0d_cfg_err", v),
                    {cfg_err_s[vecs[v].inst], busy_s[vecs[v].inst],
                     mul_en_s[vecs[v].inst], acc_load_s[vecs[v].inst]}, 4'b1000);
                tick();
                chk($sformatf("vec%0d_err_pulse_end", v),
                    {cfg_err_s[vecs[v].inst], busy_s[vecs[v].inst],
                     mul_en_s[vecs[v].inst], acc_load_s[vecs[v].inst]}, 4'b0000);
            end
        end

        // Backpressure: result and flags hold; start inside the window is ignored.
        out_ready_s[0] = 1'b0;
        run_pass(0, 10, 13, 16'h02C2, 1'b0, "bp");
        ystore = y_s[0];
        stable = 1'b1;
        no_err = 1'b1;
        for (int c = 0; c < 20; c++) begin
            start_s[0] = (c % 3) != 2;
            n_in_s[0]  = (c % 2 == 1) ? 5'd0 : 5'd5;
            tick();
            if (!out_valid_s[0] || !busy_s[0] || y_s[0] !== ystore) stable = 1'b0;
            if (cfg_err_s[0]) no_err = 1'b0;
        end
        start_s[0] = 1'b0;
        chk("bp_hold", stable, 1'b1);
        chk("bp_no_cfg_err", no_err, 1'b1);
        out_ready_s[0] = 1'b1;
        tick();
        chk("bp_release", {out_valid_s[0], busy_s[0], cfg_err_s[0]}, 3'b000);

        // Reset in the middle of MAC at k=4.
        start_s[0] = 1'b1;
        n_in_s[0]  = 5'd10;
        tick();
        start_s[0] = 1'b0;
        edges = 0;
        while (!(mul_en_s[0] && mul_sel_s[0] == 4'd4) && edges < 20) begin
            tick();
            edges++;
        end
        chk("rst_reach_k4", {mul_en_s[0], mul_sel_s[0]}, {1'b1, 4'd4});
        reset = 1'b1;
        tick();
        chk("rst_mid_pass",
            {busy_s[0], cfg_err_s[0], mul_en_s[0], acc_load_s[0], acc_en_s[0],
             out_valid_s[0], mul_sel_s[0], y_s[0]}, '0);
        reset = 1'b0;
        tick();
        run_pass(0, 10, 13, 16'h02C2, 1'b1, "after_rst");

        // Back-to-back: start held from the out_valid cycle onward. The handshake edge
        // ignores it, and the first IDLE cycle accepts it.
        start_s[0] = 1'b1;
        n_in_s[0]  = 5'd10;
        tick();
        start_s[0] = 1'b0;
        edges = 0;
        while (!out_valid_s[0] && edges < 60) begin
            tick();
            edges++;
        end
        chk("b2b_first_latency", 128'(edges), 128'd13);
        chk("b2b_first_y", y_s[0], yexp(16'h02C2));
        start_s[0] = 1'b1;
        n_in_s[0]  = 5'd3;
        tick();
        chk("b2b_handshake_edge", {busy_s[0], out_valid_s[0], cfg_err_s[0]}, 3'b000);
        tick();
        start_s[0] = 1'b0;
        chk("b2b_second_accept", {busy_s[0], acc_load_s[0]}, 2'b11);
        edges = 0;
        while (!out_valid_s[0] && edges < 60) begin
            tick();
            edges++;
        end
        chk("b2b_second_latency", 128'(edges), 128'd6);
        chk("b2b_second_y", y_s[0], yexp(16'h011E));
        tick();
        chk("b2b_release", {out_valid_s[0], busy_s[0]}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
